// File: rtl/led_act_pkg.sv
// Shared definitions for the LED activity stretcher: channel FSM encoding and
// default timing for a 40 MHz system clock.
package led_act_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } led_st_e;

    // 50 ms on / 50 ms off at 40 MHz.
    localparam int unsigned DEF_ON_CYCLES  = 2000000;
    localparam int unsigned DEF_GAP_CYCLES = 2000000;
    localparam int unsigned DEF_CNT_W      = 22;

    // Two RX links followed by two TX links.
    localparam int unsigned NUM_CH = 4;

endpackage

// File: rtl/led_act_stretch_if.sv
// Activity-strobe inputs and stretched LED requests of the LED activity stretcher.
interface led_act_stretch_if;

    logic [1:0] i_rx_act;
    logic [1:0] i_tx_act;
    logic [1:0] o_rx_led;
    logic [1:0] o_tx_led;

    modport master (
        output i_rx_act,
        output i_tx_act,
        input  o_rx_led,
        input  o_tx_led
    );

    modport slave (
        input  i_rx_act,
        input  i_tx_act,
        output o_rx_led,
        output o_tx_led
    );

endinterface

// File: rtl/led_act_ch.sv
// One LED activity channel: optional input synchronizer, rising-edge detect and
// an on/gap stretch FSM with a single pending-request bit. Macro: LED_ACT_SYNC_EN.
module led_act_ch
    import led_act_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = DEF_ON_CYCLES,
    parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic act,
    output logic led
);

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    logic act_s;

`ifdef LED_ACT_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= act;
            sync2_q <= sync1_q;
        end
    end

    assign act_s = sync2_q;
`else
    assign act_s = act;
`endif

    led_st_e          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pend_q;
    logic             act_d_q;
    logic             led_q;
    logic             act_rise;

    // History reg resets to 0, so an input already high at reset release counts as a rise.
    assign act_rise = act_s & ~act_d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            act_d_q <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            act_d_q <= act_s;
            case (state_q)
                ST_IDLE: begin
                    if (act_rise) begin
                        state_q <= ST_ON;
                        cnt_q   <= ON_LOAD;
                        led_q   <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (act_rise) begin
                        pend_q <= 1'b1;
                    end
                    if (cnt_q == '0) begin
                        state_q <= ST_GAP;
                        cnt_q   <= GAP_LOAD;
                        led_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        // A rise in the last gap cycle re-arms just like a stored request.
                        if (pend_q || act_rise) begin
                            state_q <= ST_ON;
                            cnt_q   <= ON_LOAD;
                            pend_q  <= 1'b0;
                            led_q   <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (act_rise) begin
                            pend_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    pend_q  <= 1'b0;
                    led_q   <= 1'b0;
                end
            endcase
        end
    end

    assign led = led_q;

endmodule

// File: rtl/led_act_stretch.sv
// LED activity stretcher: four independent stretch channels turning SFP link
// activity strobes into visible RX/TX LED blinks. Macro: LED_ACT_SYNC_EN.
module led_act_stretch
    import led_act_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = DEF_ON_CYCLES,
    parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic            i_clk,
    input  logic            i_res,
    led_act_stretch_if.slave bus
);

    logic [NUM_CH-1:0] act;
    logic [NUM_CH-1:0] led;

    // Channels 0..1 are RX links, 2..3 are TX links.
    assign act = {bus.i_tx_act, bus.i_rx_act};

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            led_act_ch #(
                .ON_CYCLES  (ON_CYCLES),
                .GAP_CYCLES (GAP_CYCLES),
                .CNT_W      (CNT_W)
            ) u_ch (
                .clk (i_clk),
                .rst (i_res),
                .act (act[g]),
                .led (led[g])
            );
        end
    endgenerate

    assign bus.o_rx_led = led[1:0];
    assign bus.o_tx_led = led[3:2];

endmodule

// File: tb/tb_led_act_stretch.sv
// Randomized self-checking bench for led_act_stretch against a pulse-schedule
// reference model (start cycle / busy window / pending flag per channel).
module tb_led_act_stretch;

    localparam int ON   = 8;
    localparam int GAP  = 4;
    localparam int MAXC = 4096;
`ifdef LED_ACT_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif

    logic clk;
    logic res;
    led_act_stretch_if bus ();

    led_act_stretch #(
        .ON_CYCLES  (ON),
        .GAP_CYCLES (GAP),
        .CNT_W      (4)
    ) dut (
        .i_clk (clk),
        .i_res (res),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // Reference model: per channel, the cycle the current pulse starts, the last
    // cycle of its gap window, and whether another pulse has been requested.
    bit   raw   [4][MAXC];
    bit   rst_h [MAXC];
    int   s_st  [4];
    int   b_end [4];
    bit   pend  [4];
    logic [3:0] exp_led = 4'b0;
    int   cyc = 0;

    function automatic bit cur_in(int ch, int m);
        if (m < 0) return 1'b0;
        if (D == 0) return raw[ch][m];
        if (m < 2) return 1'b0;
        if (rst_h[m-1] || rst_h[m-2]) return 1'b0;
        return raw[ch][m-2];
    endfunction

    function automatic bit prev_in(int ch, int m);
        if (m < 1 || rst_h[m-1]) return 1'b0;
        return cur_in(ch, m - 1);
    endfunction

    always @(posedge clk) begin
        if (cyc < MAXC - 1) begin
            rst_h[cyc] = res;
            for (int ch = 0; ch < 4; ch++) begin
                raw[ch][cyc] = (ch < 2) ? bus.i_rx_act[ch] : bus.i_tx_act[ch-2];
            end
            for (int ch = 0; ch < 4; ch++) begin
                if (res) begin
                    s_st[ch]  = -1000;
                    b_end[ch] = -1;
                    pend[ch]  = 1'b0;
                end else begin
                    if (cur_in(ch, cyc) && !prev_in(ch, cyc)) begin
                        if (cyc > b_end[ch]) begin
                            s_st[ch]  = cyc + 1;
                            b_end[ch] = cyc + ON + GAP;
                        end else begin
                            pend[ch] = 1'b1;
                        end
                    end
                    if (cyc == b_end[ch] && pend[ch]) begin
                        s_st[ch]  = cyc + 1;
                        b_end[ch] = cyc + ON + GAP;
                        pend[ch]  = 1'b0;
                    end
                end
                exp_led[ch] = (cyc + 1 >= s_st[ch]) && (cyc + 1 <= s_st[ch] + ON - 1);
            end
            cyc++;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            res          = 1'b0;
            bus.i_rx_act = 2'b00;
            bus.i_tx_act = 2'b00;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            res          = 1'b1;
            bus.i_rx_act = 2'($urandom);
            bus.i_tx_act = 2'($urandom);
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if ({bus.o_tx_led, bus.o_rx_led} !== 4'b0000) begin
                    errors++;
                    $display("FAIL reset_hold cyc=%0d led=%b expected=0000", cyc,
                             {bus.o_tx_led, bus.o_rx_led});
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            res          = 1'b0;
            bus.i_rx_act = 2'b00;
            bus.i_tx_act = 2'b00;
            @(negedge clk);
            checks++;
            if ({bus.o_tx_led, bus.o_rx_led} !== exp_led) begin
                errors++;
                $display("FAIL reset_release cyc=%0d led=%b expected=%b", cyc,
                         {bus.o_tx_led, bus.o_rx_led}, exp_led);
            end
        end
    endtask

    task automatic test_single_pulse();
        int hi = 0;
        int first = -1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            bus.i_rx_act = {1'b0, 1'(i == 10)};
            @(negedge clk);
            checks++;
            if ({bus.o_tx_led, bus.o_rx_led} !== exp_led) begin
                errors++;
                $display("FAIL single_pulse cyc=%0d led=%b expected=%b", cyc,
                         {bus.o_tx_led, bus.o_rx_led}, exp_led);
            end
            if (bus.o_rx_led[0] === 1'b1) begin
                hi++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (hi !== ON || first !== 11 + D) begin
            errors++;
            $display("FAIL single_pulse_shape high=%0d first=%0d expected high=%0d first=%0d",
                     hi, first, ON, 11 + D);
        end
    endtask

    task automatic test_continuous();
        int last_rise = -1;
        bit prev = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            bus.i_tx_act = {1'(((i >> 1) & 1) == 0), 1'b0};
            @(negedge clk);
            checks++;
            if ({bus.o_tx_led, bus.o_rx_led} !== exp_led) begin
                errors++;
                $display("FAIL continuous cyc=%0d led=%b expected=%b", cyc,
                         {bus.o_tx_led, bus.o_rx_led}, exp_led);
            end
            if (bus.o_tx_led[1] === 1'b1 && !prev) begin
                if (last_rise >= 0) begin
                    checks++;
                    if (i - last_rise !== ON + GAP) begin
                        errors++;
                        $display("FAIL continuous_period got=%0d expected=%0d",
                                 i - last_rise, ON + GAP);
                    end
                end
                last_rise = i;
            end
            prev = (bus.o_tx_led[1] === 1'b1);
        end
        bus.i_tx_act = 2'b00;
    endtask

    task automatic test_stuck_high();
        int hi = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            bus.i_rx_act = {1'(i >= 5), 1'b0};
            @(negedge clk);
            checks++;
            if ({bus.o_tx_led, bus.o_rx_led} !== exp_led) begin
                errors++;
                $display("FAIL stuck_high cyc=%0d led=%b expected=%b", cyc,
                         {bus.o_tx_led, bus.o_rx_led}, exp_led);
            end
            if (bus.o_rx_led[1] === 1'b1) hi++;
        end
        checks++;
        if (hi !== ON) begin
            errors++;
            $display("FAIL stuck_high_count got=%0d expected=%0d", hi, ON);
        end
        bus.i_rx_act = 2'b00;
    endtask

    task automatic test_last_gap_edge();
        int hi = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            bus.i_rx_act = {1'b0, 1'(i == 0 || i == ON + GAP)};
            @(negedge clk);
            checks++;
            if ({bus.o_tx_led, bus.o_rx_led} !== exp_led) begin
                errors++;
                $display("FAIL last_gap_edge cyc=%0d led=%b expected=%b", cyc,
                         {bus.o_tx_led, bus.o_rx_led}, exp_led);
            end
            if (bus.o_rx_led[0] === 1'b1) hi++;
            if (i == ON + GAP + 1 + D) begin
                checks++;
                if (bus.o_rx_led[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL last_gap_rearm led=%b expected=1", bus.o_rx_led[0]);
                end
            end
        end
        checks++;
        if (hi !== 2 * ON) begin
            errors++;
            $display("FAIL last_gap_count got=%0d expected=%0d", hi, 2 * ON);
        end
    endtask

    task automatic test_reset_mid();
        int hi = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk);
            #1;
            bus.i_rx_act = {1'b0, 1'(i == 0 || i >= 4 + D)};
            res          = (i == 4 + D);
            @(negedge clk);
            checks++;
            if ({bus.o_tx_led, bus.o_rx_led} !== exp_led) begin
                errors++;
                $display("FAIL reset_mid cyc=%0d led=%b expected=%b", cyc,
                         {bus.o_tx_led, bus.o_rx_led}, exp_led);
            end
            if (i == 5 + D) begin
                checks++;
                if ({bus.o_tx_led, bus.o_rx_led} !== 4'b0000) begin
                    errors++;
                    $display("FAIL reset_mid_clear led=%b expected=0000",
                             {bus.o_tx_led, bus.o_rx_led});
                end
            end
            if (i > 5 + D && bus.o_rx_led[0] === 1'b1) hi++;
        end
        checks++;
        if (hi !== ON) begin
            errors++;
            $display("FAIL reset_mid_repulse got=%0d expected=%0d", hi, ON);
        end
        res          = 1'b0;
        bus.i_rx_act = 2'b00;
    endtask

    task automatic test_parallel();
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            bus.i_rx_act = (i == 3) ? 2'b11 : 2'b00;
            bus.i_tx_act = (i == 3) ? 2'b11 : 2'b00;
            @(negedge clk);
            checks++;
            if ({bus.o_tx_led, bus.o_rx_led} !== exp_led) begin
                errors++;
                $display("FAIL parallel cyc=%0d led=%b expected=%b", cyc,
                         {bus.o_tx_led, bus.o_rx_led}, exp_led);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] a = 4'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            for (int ch = 0; ch < 4; ch++) begin
                if ($urandom_range(5) == 0) a[ch] = ~a[ch];
            end
            bus.i_rx_act = a[1:0];
            bus.i_tx_act = a[3:2];
            res          = ($urandom_range(99) == 0);
            @(negedge clk);
            checks++;
            if ({bus.o_tx_led, bus.o_rx_led} !== exp_led) begin
                errors++;
                $display("FAIL random cyc=%0d led=%b expected=%b", cyc,
                         {bus.o_tx_led, bus.o_rx_led}, exp_led);
            end
        end
        res = 1'b0;
    endtask

    initial begin
        res          = 1'b1;
        bus.i_rx_act = 2'b00;
        bus.i_tx_act = 2'b00;
        test_reset();
        idle(20);
        test_single_pulse();
        idle(20);
        test_continuous();
        idle(20);
        test_stuck_high();
        idle(20);
        test_last_gap_edge();
        idle(20);
        test_reset_mid();
        idle(20);
        test_parallel();
        idle(20);
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
